// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: filtered, triggerable capture FIFO for retired write-back records.
// Ports: clk/reset (async active-low); wb_* retired-record inputs; cap_mode filter;
// arm/trig_en/trig_pc/post_cnt session control; flush clears storage and counters;
// out_valid/out_ready/out_rec show-ahead drain port; count occupancy, drop_cnt lost
// records, state FSM state. out_rec carries a zero pad bit above seq.
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int XLEN = 32,
  parameter int SEQW = 8,
  parameter bit OVERWRITE = 1'b0,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int RW = 5 * XLEN + 8 + SEQW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_instruction,
  input  logic [XLEN-1:0] wb_write_data,
  input  logic [XLEN-1:0] wb_mem_addr,
  input  logic [XLEN-1:0] wb_mem_wdata,
  input  logic [4:0]      wb_rd_addr,
  input  logic            wb_RegWrite,
  input  logic            wb_MemWrite,
  input  logic [1:0]      cap_mode,
  input  logic            arm,
  input  logic            trig_en,
  input  logic [XLEN-1:0] trig_pc,
  input  logic [7:0]      post_cnt,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RW-1:0]   out_rec,
  output logic [CW-1:0]   count,
  output logic [15:0]     drop_cnt,
  output logic [1:0]      state
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FROZEN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] drop_q, drop_d;
  logic [SEQW-1:0] seq_q, seq_d;
  logic [7:0] post_q, post_d;
  logic [RW-1:0] mem [DEPTH];
  logic qual, push, pop, full, we, adv, last;
  // Pushes are suppressed on arm and flush cycles so a record never straddles a counter clear.
  always_comb begin
    qual = wb_valid && (cap_mode == 2'd0 || (cap_mode[0] && wb_RegWrite) || (cap_mode[1] && wb_MemWrite));
    push = qual && !arm && !flush && (state_q == CAPTURE || (state_q == ARMED && wb_pc == trig_pc));
    full = cnt_q == CW'(DEPTH);
    pop = out_valid && out_ready && !flush;
    we = push && (!full || pop || OVERWRITE);
    adv = pop || (we && full);
    last = post_cnt != 8'd0 && ({1'b0, post_q} + 9'd1 >= {1'b0, post_cnt});
    wr_d = flush ? '0 : wr_q + AW'(we);
    rd_d = flush ? '0 : rd_q + AW'(adv);
    cnt_d = flush ? '0 : cnt_q + CW'(we && !adv) - CW'(adv && !we);
    drop_d = (flush || arm) ? '0 : drop_q + 16'(push && full && !pop && drop_q != 16'hFFFF);
    seq_d = (flush || arm) ? '0 : seq_q + SEQW'(push);
    post_d = (flush || arm) ? '0 : post_q + 8'(push);
    state_d = arm ? (trig_en ? ARMED : CAPTURE) : push ? (last ? FROZEN : CAPTURE) : state_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      drop_q <= '0;
      seq_q <= '0;
      post_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
      seq_q <= seq_d;
      post_q <= post_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wr_q] <= {1'b0, seq_q, wb_rd_addr, wb_RegWrite, wb_MemWrite, wb_pc, wb_instruction, wb_write_data, wb_mem_addr, wb_mem_wdata};
  end
  assign out_valid = cnt_q != '0;
  assign out_rec = out_valid ? mem[rd_q] : '0;
  assign count = cnt_q;
  assign drop_cnt = drop_q;
  assign state = state_q;
endmodule
